settings_spi_rx: RTL and testbench
==================================

Name: settings_spi_rx

Overview:
- SPI-peripheral receiver that turns 16-bit MCU settings frames into the parallel `dataIn` word consumed by the settings `memory` block.
- It is the writer side of the settings interface:
  - deserializes sdi MSB-first;
  - validates frame length and address nibble;
  - holds the last accepted word stable on `dataOut`;
  - pulses `dataValid` once per accepted frame.
- Sits between the top-level SPI pins and `memory`.

Parameters:
- WORD_W, 16, frame length in bits; `dataOut` width.
- ADDR_W, 4, width of the address field in frame bits [WORD_W-1 : WORD_W-ADDR_W].
- NUM_ADDR, 4, number of valid settings addresses; address ≥ NUM_ADDR is rejected.
- SYNC_STAGES, 2, flip-flop stages on each of sck, sdi, csN.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- sck  input  1  SPI clock from MCU, mode 0 (idle low, sample on rising edge).
- csN  input  1  SPI chip select, active-low; one frame per low period.
- sdi  input  1  SPI data in, MSB first.
- sdo  output  1  SPI data out; see Optional Feature.
- dataOut  output  WORD_W  last accepted frame; feeds `memory` `dataIn`.
- dataValid  output  1  one-clk pulse when `dataOut` takes a new frame.
- frameErr  output  1  one-clk pulse when a frame is rejected.

Behaviour:
- Reset values: dataOut=0, dataValid=0, frameErr=0, sdo=0, shift register=0, bit counter=0, synchronizers=idle values (sck=0, csN=1, sdi=0).
- Inputs sck, csN, sdi each pass through SYNC_STAGES flops.
- Edges are detected on the synchronized signals by comparing against a delayed copy.
- Requirement: clk ≥ 4× sck frequency.
- States:
  - IDLE: wait for synchronized csN falling. Then clear shift register and counter, go to SHIFT.
  - SHIFT: on each synchronized sck rising edge, shift sdi into the LSB and increment the counter (saturates at WORD_W+1). On synchronized csN rising, go to CHECK.
  - CHECK, one cycle: a frame is accepted iff counter == WORD_W and the address field < NUM_ADDR.
    - Accept: dataOut ← shift register and dataValid=1 in the same cycle.
    - Reject: frameErr=1 and dataOut unchanged.
    - Either way, return to IDLE.
  - WAIT_CS: entered when reset releases while synchronized csN=0, or on csN falling with sck high. Ignore everything until csN rises, then go to IDLE. No frameErr for this discarded frame.
- Latency:
  - Pin csN rising → dataValid high is exactly SYNC_STAGES+2 clk cycles (sync stages, edge detect, CHECK).
  - dataOut changes in the same cycle dataValid is high.
- dataOut holds its value indefinitely between accepted frames; `memory` samples it continuously.
- Boundary cases:
  - Fewer than WORD_W sck edges (including zero) → reject.
  - More than WORD_W edges → reject (counter saturation flags overflow).
  - An sck rising edge in the same clk cycle as csN rising is counted before CHECK.
  - Back-to-back frames with csN high for ≥ SYNC_STAGES+2 clk cycles are both processed.
  - Reset mid-frame: all state returns to reset values and the partial frame is lost. If csN is still low at release, enter WAIT_CS.
- dataValid and frameErr are never high in the same cycle.

Optional Feature:
- Macro: SETTINGS_RX_ECHO_EN.
- Defined: sdo echoes the previously accepted dataOut during the next frame.
  - On csN falling, an echo register loads dataOut.
  - The MSB is driven immediately.
  - Each synchronized sck falling edge shifts the next bit out, MSB first.
  - sdo=0 while csN is high.
  - The MCU reads the echo to verify the prior write.
- Undefined: sdo is constant 0 and no echo register is built.

Test Plan:
- Reset then send 0x1040 (16 sck, csN rises) → dataValid pulses once, exactly 4 clk cycles after csN rises; dataOut=0x1040; frameErr=0.
- Send 0x0000, 0x1041, 0x2402, 0x3147 back-to-back → four dataValid pulses; dataOut steps through each value and holds 0x3147.
- Send 0x5123 (address 5 ≥ NUM_ADDR) → frameErr pulse, no dataValid, dataOut keeps its previous value 0x3147.
- Send 15 bits of 0x2400, then 17 bits → frameErr on each, dataOut unchanged.
- Assert rst after 8 bits of 0x3144 with csN held low, release, finish the frame, then send 0x0001 → dataOut=0 after reset, no pulse for the truncated frame, then dataOut=0x0001 with dataValid.
- With SETTINGS_RX_ECHO_EN: send 0x1040, then 0x2400 → sdo bits captured on sck rising during the second frame equal 0x1040.

Source files
------------

// File: rtl/settings_spi_rx.sv
// SPI mode-0 receiver that turns 16-bit MCU settings frames into the parallel word for the settings memory.
// Define SETTINGS_RX_ECHO_EN to echo the previously accepted word on sdo during the next frame.
module settings_spi_rx #(
  parameter int WORD_W      = 16,
  parameter int ADDR_W      = 4,
  parameter int NUM_ADDR    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              csN,
  input  logic              sdi,
  output logic              sdo,
  output logic [WORD_W-1:0] dataOut,
  output logic              dataValid,
  output logic              frameErr
);

  localparam int CNT_W = $clog2(WORD_W + 2);
  localparam int SET_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(WORD_W + 1);
  localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(NUM_ADDR);
  localparam logic [SET_W-1:0]  SETTLE   = SET_W'(SYNC_STAGES);

  typedef enum logic [2:0] {INIT, IDLE, SHIFT, CHECK, WAIT_CS} state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sck_sync_reg, cs_sync_reg, sdi_sync_reg;
  logic                   sck_d_reg, cs_d_reg;
  logic                   sck_s, cs_s, sdi_s;
  logic                   sck_rise, cs_rise, cs_fall;

  logic [WORD_W-1:0] shift_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [SET_W-1:0]  settle_reg;
  logic [WORD_W-1:0] data_out_reg;
  logic              data_valid_reg, frame_err_reg;

  logic              start, shift_en, accept, reject;
  logic [ADDR_W-1:0] addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_reg <= '0;
      cs_sync_reg  <= '1;
      sdi_sync_reg <= '0;
      sck_d_reg    <= 1'b0;
      cs_d_reg     <= 1'b1;
    end else begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        sck_sync_reg[i] <= sck_sync_reg[i-1];
        cs_sync_reg[i]  <= cs_sync_reg[i-1];
        sdi_sync_reg[i] <= sdi_sync_reg[i-1];
      end
      sck_sync_reg[0] <= sck;
      cs_sync_reg[0]  <= csN;
      sdi_sync_reg[0] <= sdi;
      sck_d_reg       <= sck_s;
      cs_d_reg        <= cs_s;
    end
  end

  assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
  assign cs_s     = cs_sync_reg[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_reg[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d_reg;
  assign cs_rise  = cs_s & ~cs_d_reg;
  assign cs_fall  = ~cs_s & cs_d_reg;
  assign addr     = shift_reg[WORD_W-1 -: ADDR_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= INIT;
    else     state_reg <= state_next;
  end

  // INIT lets the synchronizers fill after reset so a csN already low at release is
  // recognised as a level (discarded frame) rather than mistaken for a falling edge.
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    shift_en   = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    case (state_reg)
      INIT: begin
        if (settle_reg == SETTLE) state_next = cs_s ? IDLE : WAIT_CS;
      end
      IDLE: begin
        if (cs_fall) begin
          if (sck_s) begin
            state_next = WAIT_CS;
          end else begin
            state_next = SHIFT;
            start      = 1'b1;
          end
        end
      end
      SHIFT: begin
        shift_en = sck_rise;
        if (cs_rise) state_next = CHECK;
      end
      CHECK: begin
        if (cnt_reg == CNT_FULL && {1'b0, addr} < ADDR_LIM) accept = 1'b1;
        else                                                 reject = 1'b1;
        state_next = IDLE;
      end
      WAIT_CS: begin
        if (cs_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The counter stops one past a full word so any overlong frame stays distinguishable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg      <= '0;
      cnt_reg        <= '0;
      settle_reg     <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      data_valid_reg <= accept;
      frame_err_reg  <= reject;
      if (accept) data_out_reg <= shift_reg;
      if (start) begin
        shift_reg <= '0;
        cnt_reg   <= '0;
      end else if (shift_en) begin
        shift_reg <= {shift_reg[WORD_W-2:0], sdi_s};
        if (cnt_reg != CNT_SAT) cnt_reg <= cnt_reg + 1'b1;
      end
      if (state_reg == INIT && settle_reg != SETTLE) settle_reg <= settle_reg + 1'b1;
    end
  end

  assign dataOut   = data_out_reg;
  assign dataValid = data_valid_reg;
  assign frameErr  = frame_err_reg;

`ifdef SETTINGS_RX_ECHO_EN
  logic [WORD_W-1:0] echo_reg;
  logic              sck_fall;

  assign sck_fall = ~sck_s & sck_d_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 echo_reg <= '0;
    else if (start)                          echo_reg <= data_out_reg;
    else if (state_reg == SHIFT && sck_fall) echo_reg <= {echo_reg[WORD_W-2:0], 1'b0};
  end

  assign sdo = (state_reg == SHIFT) && !cs_s && echo_reg[WORD_W-1];
`else
  assign sdo = 1'b0;
`endif

endmodule

// File: tb/tb_settings_spi_rx.sv
// Directed plus randomized frames for settings_spi_rx, checked against a frame-level acceptance model.
// Echo checks are active when SETTINGS_RX_ECHO_EN is defined.
module tb_settings_spi_rx;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, sck, csN, sdi;
  logic         sdo, dataValid, frameErr;
  logic [W-1:0] dataOut;

  int n_assert = 0, n_fail = 0;
  int cyc = 0;
  int nvalid = 0, nerr = 0, both_high = 0;
  int last_valid_cyc = 0, last_err_cyc = 0, rise_cyc = 0;
  logic [15:0] model_out;
  logic [31:0] echo_cap;

  always #5 clk = ~clk;

  settings_spi_rx dut (
    .clk(clk), .rst(rst), .sck(sck), .csN(csN), .sdi(sdi),
    .sdo(sdo), .dataOut(dataOut), .dataValid(dataValid), .frameErr(frameErr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dataValid) begin nvalid++; last_valid_cyc = cyc; end
    if (frameErr)  begin nerr++;   last_err_cyc   = cyc; end
    if (dataValid && frameErr) both_high++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sdi = b;
    tick(2);
    echo_cap = {echo_cap[30:0], sdo};
    sck = 1'b1;
    tick(4);
    sck = 1'b0;
    tick(2);
  endtask

  // One complete frame; merge raises csN in the same instant as the final sck rise.
  task automatic frame(input string tag, input logic [31:0] bits, input int nbits,
                       input bit merge, input int gap);
    int v0, e0;
    logic acc;
    logic [15:0] prev;
    v0 = nvalid;
    e0 = nerr;
    prev = model_out;
    acc = (nbits == W) && (bits[15:12] < 4'd4);
    echo_cap = '0;
    csN = 1'b0;
    tick(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (merge && i == 0) begin
        sdi = bits[i];
        tick(2);
        echo_cap = {echo_cap[30:0], sdo};
        sck = 1'b1;
        csN = 1'b1;
        rise_cyc = cyc;
        tick(4);
        sck = 1'b0;
      end else begin
        send_bit(bits[i]);
      end
    end
    if (!(merge && nbits > 0)) begin
      csN = 1'b1;
      rise_cyc = cyc;
    end
    tick(gap);
    if (acc) model_out = bits[15:0];
    chk({tag, "_valid"}, 32'(nvalid - v0), 32'(acc));
    chk({tag, "_err"},   32'(nerr - e0),   32'(!acc));
    chk({tag, "_dout"},  32'(dataOut),     32'(model_out));
    chk({tag, "_sdo_idle"}, 32'(sdo), 32'd0);
    if (acc) chk({tag, "_lat"}, 32'(last_valid_cyc - rise_cyc), 32'd4);
    else     chk({tag, "_errlat"}, 32'(last_err_cyc - rise_cyc), 32'd4);
`ifdef SETTINGS_RX_ECHO_EN
    if (nbits == W) chk({tag, "_echo"}, {16'd0, echo_cap[15:0]}, {16'd0, prev});
`endif
    $display("frame %s bits=%0d value=%h accept=%0d dataOut=%h", tag, nbits, bits, acc, dataOut);
  endtask

  initial begin
    int v0, e0, len, gap;
    logic [31:0] val;
    logic [15:0] part;
    rst = 1'b1; sck = 1'b0; csN = 1'b1; sdi = 1'b0;
    model_out = '0;
    echo_cap = '0;
    @(negedge clk);
    tick(4);
    chk("rst_dout",  32'(dataOut),   32'd0);
    chk("rst_valid", 32'(dataValid), 32'd0);
    chk("rst_err",   32'(frameErr),  32'd0);
    chk("rst_sdo",   32'(sdo),       32'd0);
    rst = 1'b0;
    tick(6);

    frame("f1040", 32'h1040, 16, 1'b0, 10);
    frame("f0000", 32'h0000, 16, 1'b0, 6);
    frame("f1041", 32'h1041, 16, 1'b0, 6);
    frame("f2402", 32'h2402, 16, 1'b0, 6);
    frame("f3147", 32'h3147, 16, 1'b0, 10);
    frame("badaddr", 32'h5123, 16, 1'b0, 10);
    frame("short15", 32'h2400, 15, 1'b0, 10);
    frame("long17", 32'h4801, 17, 1'b0, 10);
    frame("empty", 32'h0, 0, 1'b0, 10);
    frame("merged", 32'h2203, 16, 1'b1, 10);

    // Reset in the middle of a frame with csN still low at release
    part = 16'h3144;
    csN = 1'b0;
    tick(4);
    for (int i = 15; i >= 8; i--) send_bit(part[i]);
    rst = 1'b1;
    tick(3);
    chk("midrst_dout",  32'(dataOut),   32'd0);
    chk("midrst_valid", 32'(dataValid), 32'd0);
    rst = 1'b0;
    model_out = '0;
    v0 = nvalid;
    e0 = nerr;
    for (int i = 7; i >= 0; i--) send_bit(part[i]);
    csN = 1'b1;
    tick(10);
    chk("trunc_valid", 32'(nvalid - v0), 32'd0);
    chk("trunc_err",   32'(nerr - e0),   32'd0);
    chk("trunc_dout",  32'(dataOut),     32'd0);
    $display("frame truncated-by-reset dataOut=%h", dataOut);
    frame("post_rst", 32'h0001, 16, 1'b0, 10);

    frame("echo_a", 32'h1040, 16, 1'b0, 10);
    frame("echo_b", 32'h2400, 16, 1'b0, 10);

    for (int k = 0; k < 24; k++) begin
      int r;
      r = $urandom_range(0, 9);
      len = (r < 7) ? 16 : ((r == 7) ? 15 : 17);
      val = $urandom;
      val[15:12] = 4'($urandom_range(0, 7));
      gap = $urandom_range(5, 12);
      frame($sformatf("rnd%0d", k), val & ((32'd1 << len) - 32'd1), len, 1'b0, gap);
    end

    chk("exclusive", 32'(both_high), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
